// File: rtl/prog_loader_pkg.sv
// Shared types for the program loader: FSM state encoding and the stream byte width.
// The optional checksum stage is controlled by PROG_LOADER_CHECKSUM_EN.
package prog_loader_pkg;

  localparam int unsigned LOADER_BYTE_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StCsum,
    StDone,
    StErr
  } loader_state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Host-to-loader valid/ready byte stream. The host drives valid/data, and the loader
// drives ready.
interface prog_loader_if;
  import prog_loader_pkg::*;

  logic                     in_valid;
  logic [LOADER_BYTE_W-1:0] in_data;
  logic                     in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/prog_loader_instr_ram.sv
// Instruction store: synchronous write port, asynchronous read port, 2**ADDR_W bytes.
// Contents are never reset, so a program survives reset and partial reloads.
module prog_loader_instr_ram
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [ADDR_W-1:0]        waddr_i,
  input  logic [LOADER_BYTE_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0]        raddr_i,
  output logic [LOADER_BYTE_W-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [LOADER_BYTE_W-1:0] mem [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/prog_loader.sv
// Length-prefixed byte-stream loader that fills instruction RAM and then releases the CPU.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the payload.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  prog_loader_if.slave             host,
  input  logic [ADDR_W-1:0]        fetch_addr,
  output logic [LOADER_BYTE_W-1:0] fetch_instr,
  output logic                     cpu_run,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [LOADER_BYTE_W-1:0] byte_count
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  loader_state_e            state_q, state_d;
  logic [ADDR_W-1:0]        wr_addr_q, wr_addr_d;
  logic [LOADER_BYTE_W-1:0] remaining_q, remaining_d;
  logic [LOADER_BYTE_W-1:0] byte_count_q, byte_count_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [LOADER_BYTE_W-1:0] csum_q, csum_d;
`endif

  logic accept;
  logic len_bad;
  logic mem_we;

  // Ready depends only on registered state, so there is no path from in_valid to in_ready.
  assign busy          = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
  assign host.in_ready = busy;
  assign accept        = host.in_valid & busy;
  assign cpu_run       = (state_q == StDone);
  assign done          = (state_q == StDone);
  assign error         = (state_q == StErr);
  assign byte_count    = byte_count_q;

  assign len_bad = (host.in_data == '0) || ({24'd0, host.in_data} > Depth);

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    remaining_d  = remaining_q;
    byte_count_d = byte_count_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
`endif
    mem_we       = 1'b0;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d      = StLen;
          wr_addr_d    = '0;
          remaining_d  = '0;
          byte_count_d = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d       = '0;
`endif
        end
      end
      StLen: begin
        if (accept) begin
          if (len_bad) begin
            state_d = StErr;
          end else begin
            remaining_d = host.in_data;
            state_d     = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          mem_we       = 1'b1;
          wr_addr_d    = wr_addr_q + ADDR_W'(1);
          byte_count_d = byte_count_q + 8'd1;
          remaining_d  = remaining_q - 8'd1;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d       = csum_q ^ host.in_data;
          if (remaining_q == 8'd1) state_d = StCsum;
`else
          if (remaining_q == 8'd1) state_d = StDone;
`endif
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      StCsum: begin
        if (accept) begin
          state_d = (host.in_data == csum_q) ? StDone : StErr;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      wr_addr_q    <= '0;
      remaining_q  <= '0;
      byte_count_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      remaining_q  <= remaining_d;
      byte_count_q <= byte_count_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q       <= csum_d;
`endif
    end
  end

  prog_loader_instr_ram #(
    .ADDR_W(ADDR_W)
  ) u_instr_ram (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (wr_addr_q),
    .wdata_i (host.in_data),
    .raddr_i (fetch_addr),
    .rdata_o (fetch_instr)
  );

endmodule

// File: doc/prog_loader.md
# prog_loader

Writable instruction store plus byte-stream loader that sits directly upstream of the CPU fetch path, replacing the fixed instruction ROM. A host streams a length-prefixed program over a valid/ready byte interface; the loader writes it into instruction RAM while holding the CPU idle. It then releases the CPU via `cpu_run`, and the CPU fetches through the combinational read port using its PC.

## Interface
- `ADDR_W`, default 8: instruction address width; RAM depth = 2**ADDR_W bytes.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a load; honoured only in IDLE, DONE or ERR.
- `in_valid`  in  1  host byte valid.
- `in_data`  in  8  host byte.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `fetch_addr`  in  ADDR_W  CPU PC.
- `fetch_instr`  out  8  instruction at `fetch_addr`, combinational.
- `cpu_run`  out  1  CPU may execute; integration gates CPU reset/enables with it.
- `busy`  out  1  load in progress (LEN, DATA or CSUM).
- `done`  out  1  last load completed successfully.
- `error`  out  1  last load rejected.
- `byte_count`  out  8  payload bytes written in the current/last load.

## Operation
- States: IDLE, LEN, DATA, CSUM, DONE, ERR.
- IDLE: `start` -> LEN, clear `wr_addr`, `remaining`, `byte_count`, and running checksum.
- LEN: on accept, N = `in_data`.
  - N == 0 or N > 2**ADDR_W -> ERR.
  - Otherwise `remaining` = N -> DATA.
- DATA: on accept, write `mem[wr_addr]` = `in_data`, then `wr_addr`++, `byte_count`++, `remaining`--, and checksum ^= `in_data`.
  - On the accept with `remaining` == 1 -> CSUM (macro on) or DONE (macro off).
- CSUM: on accept, `in_data` == checksum -> DONE, else -> ERR. The byte is not written to RAM.
- DONE: `cpu_run` = 1, `done` = 1. `start` -> LEN; `cpu_run` drops the next cycle.
- ERR: `error` = 1, `cpu_run` = 0. `start` -> LEN.
- Accept = `in_valid` & `in_ready` at a rising edge. `in_ready` = `busy`.
  - `in_valid` outside LEN/DATA/CSUM is ignored.
  - `start` while busy is ignored.
- Arithmetic: `wr_addr` is ADDR_W bits; it cannot wrap because N ≤ depth. `byte_count` saturates to N. Checksum is the 8-bit XOR of payload bytes only; the length byte is excluded.
- Read port: `fetch_instr` = `mem[fetch_addr]`, asynchronous.
  - During a load it returns old contents until that location's write edge.
  - RAM is not cleared by reset or by `start`; locations beyond N keep prior contents.

## Timing
- Reset (async assert): state = IDLE, `in_ready` = 0, `cpu_run` = 0, `busy` = 0, `done` = 0, `error` = 0, `byte_count` = 0. RAM contents are untouched.
- Reset mid-load: immediate return to IDLE; partially written RAM is retained; `done`/`error` clear.
- `start` sampled at edge T: `in_ready` = 1 from cycle T+1.
- Throughput: one byte per cycle when `in_valid` is held high.
- Full load (macro on) with `in_valid` continuous: N+2 accept cycles. `cpu_run` = 1 in the cycle after the checksum accept.
- A write becomes visible on `fetch_instr` in the cycle after its accept edge.
- All outputs except `fetch_instr` are registered or decoded from registered state; there is no combinational path from `in_valid` to `in_ready`.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined:
  - the stream is LEN, N payload bytes, then one checksum byte;
  - a mismatch goes to ERR.
- Not defined:
  - CSUM state, checksum register and `error` on mismatch are compiled out;
  - the last payload byte goes directly to DONE;
  - `error` asserts only on a bad length.

## Structure
- `prog_loader_pkg`: state enum (IDLE, LEN, DATA, CSUM, DONE, ERR) and `LOADER_BYTE_W` = 8.
- Sub-module `instr_ram`: synchronous write port, asynchronous read port, depth 2**ADDR_W × 8. The FSM, counters and checksum stay in `prog_loader`.

## Test plan
- Reset then `start`, stream 04,A1,B2,C3,D4,(csum 04) -> `done` = 1, `cpu_run` = 1; `fetch_addr` 0..3 reads A1,B2,C3,D4; `byte_count` = 4.
- Same stream with checksum byte 05 -> `error` = 1, `cpu_run` = 0, RAM 0..3 = A1..D4.
- Length byte 00 -> ERR in the cycle after the accept; no RAM write.
- `in_valid` toggling 1/0 during DATA plus `start` pulsed mid-load -> same final RAM and `done`; the `start` has no effect.
- Assert `reset` after 2 of 4 payload bytes -> IDLE immediately, all flags 0; RAM 0..1 updated, 2..3 unchanged.
- Reload from DONE with 01,7E,(7E) -> `cpu_run` low from cycle T+1 through load end; RAM[0] = 7E; RAM[1..3] keep the previous program.
